// File: rtl/rr_arbiter8_if.sv
// Request/grant bus between the requesting sub-blocks and rr_arbiter8.
//   en           arbitration enable (requester side -> arbiter)
//   req[7:0]     per-requester request (requester side -> arbiter)
//   grant_idx    current owner index, drives decoder in[2:0]
//   grant_valid  grant active, drives decoder en
//   grant[7:0]   one-hot grant, mirrors the decoder output
//   grant_count  grants issued since reset, wrapping
// master: requester side; slave: arbiter side.
interface rr_arbiter8_if;
  logic        en;
  logic [7:0]  req;
  logic [2:0]  grant_idx;
  logic        grant_valid;
  logic [7:0]  grant;
  logic [15:0] grant_count;

  modport master (
    output en, req,
    input  grant_idx, grant_valid, grant, grant_count
  );

  modport slave (
    input  en, req,
    output grant_idx, grant_valid, grant, grant_count
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   rr_arbiter8_if.slave: en, req in; grant_idx, grant_valid,
//         grant, grant_count out (all outputs registered)
// Optional feature: define ARB_TIMEOUT_EN to force rotation after MAX_HOLD
// consecutive owned cycles when another requester is waiting.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HCW      = 5
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  // Reject parameter sets the hold counter cannot represent.
  if ((MAX_HOLD < 2) || ((64'(1) << HCW) <= 64'(MAX_HOLD))) begin : g_bad_cfg
    $error("rr_arbiter8: need MAX_HOLD >= 2 and 2**HCW > MAX_HOLD");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] pick_idx;
  logic       pick_found;
  logic       owner_req;
  logic       timeout;

  // First set request in search order ptr, ptr+1, ... (3-bit sum wraps 7->0).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    for (int i = 0; i < 8; i++) begin
      if (!pick_found && bus.req[ptr + 3'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr + 3'(i);
      end
    end
  end

  assign owner_req = bus.req[bus.grant_idx];

`ifdef ARB_TIMEOUT_EN
  localparam logic [HCW-1:0] HOLD_SAT = HCW'(MAX_HOLD - 1);

  logic [HCW-1:0] hold_cnt;

  // grant is the owner's one-hot while BUSY, so this masks out the owner.
  assign timeout = (hold_cnt == HOLD_SAT) && (|(bus.req & ~bus.grant));

  // Consecutive owned cycles, saturating; cleared on each new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_SAT) begin
      hold_cnt <= hold_cnt + HCW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Grant FSM; every release leaves one dead cycle in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= 3'd0;
      bus.grant_idx   <= 3'd0;
      bus.grant_valid <= 1'b0;
      bus.grant       <= 8'd0;
      bus.grant_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && pick_found) begin
            state           <= BUSY;
            bus.grant_idx   <= pick_idx;
            bus.grant_valid <= 1'b1;
            bus.grant       <= 8'(1) << pick_idx;
            bus.grant_count <= bus.grant_count + 16'd1;
          end
        end
        BUSY: begin
          if (!owner_req || timeout) begin
            state           <= IDLE;
            bus.grant_valid <= 1'b0;
            bus.grant       <= 8'd0;
            ptr             <= bus.grant_idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
